gor: RTL and testbench
======================

GOR -- requirements
Module: gor

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of operands a, b and result y.
REQ-002 Parameter: CNT_W, default 16, width of the activity counter.
REQ-003 Port: clk  input  1  single clock; all registers update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: clr  input  1  synchronous clear of sticky and counter state, active-high.
REQ-008 Port: y  output  WIDTH  combinational bitwise OR of a and b.
REQ-009 Port: y_q  output  WIDTH  y registered one clock later.
REQ-010 Port: sticky  output  WIDTH  per-bit OR-accumulation of y since the last reset or clear.
REQ-011 Port: any  output  1  combinational reduction OR of y.
REQ-012 Port: rise  output  1  one-cycle pulse on a registered any transition from 0 to 1.
REQ-013 Port: act_cnt  output  CNT_W  saturating count of cycles in which any was 1; present only with GOR_STATS_EN.

Function
REQ-014 y SHALL equal a | b bit by bit, with zero latency and no dependence on clk, rst_n or clr.
REQ-015 The truth table per bit SHALL be 0|0=0, 0|1=1, 1|0=1, 1|1=1.
REQ-016 any SHALL equal the OR of all bits of y, combinationally.
REQ-017 y_q SHALL take the value of y at each rising clk edge, giving 1-cycle latency.
REQ-018 sticky SHALL take the value sticky | y at each edge; clr=1 SHALL load 0 instead, and clr SHALL win over a simultaneous set.
REQ-019 An internal register any_q SHALL hold the value of any from the previous edge.
REQ-020 rise SHALL be 1 for exactly one cycle when any=1 and any_q=0, and is a registered output.
REQ-021 act_cnt SHALL increment by 1 on each edge where any=1.
REQ-022 act_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap around.
REQ-023 clr=1 SHALL load act_cnt with 0, taking priority over an increment in the same cycle.
REQ-024 clr SHALL NOT affect y_q or any_q.
REQ-025 X or Z bits on a or b SHALL propagate per Verilog OR semantics: 1 dominates, otherwise the result is X.

Reset
REQ-026 When rst_n=0 at a rising clk edge, y_q, sticky, any_q, rise and act_cnt SHALL all become 0.
REQ-027 Reset SHALL take priority over clr and over all data updates.
REQ-028 y and any SHALL remain combinational and valid during reset.
REQ-029 Asserting reset in the middle of an accumulation SHALL discard all accumulated state.

Configuration
REQ-030 With macro GOR_STATS_EN defined, the act_cnt port and its counter logic SHALL be compiled in.
REQ-031 Without GOR_STATS_EN, the act_cnt port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Set WIDTH=1 with no clock, and apply (a,b) = 00, 01, 10, 11 at 10-time-unit steps -> y = 0, 1, 1, 1, each within the same time step.
REQ-033 Hold rst_n=0 for 2 edges, then release with a=1, b=0 -> y_q=1 one edge later; rise=1 for one cycle; sticky=1.
REQ-034 After REQ-033, drive a=b=0 for 3 cycles -> y_q=0 and sticky stays 1; then clr=1 for 1 cycle -> sticky=0.
REQ-035 With GOR_STATS_EN and CNT_W=4, hold a=1 for 20 cycles -> act_cnt reaches 15 and holds there; then clr=1 -> act_cnt=0.
REQ-036 With WIDTH=4, a=4'b0101 and b=4'b0011 -> y=4'b0111 and any=1; assert rst_n=0 mid-stream -> all registered outputs are 0 on the next edge.

Source files
------------

// File: rtl/gor.sv
// Registered bitwise OR with sticky accumulation, rising-activity pulse and
// an optional saturating activity counter (enabled by defining GOR_STATS_EN).
module gor #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] sticky,
  output logic             any,
  output logic             rise
`ifdef GOR_STATS_EN
  ,
  output logic [CNT_W-1:0] act_cnt
`endif
);

  logic any_q;

  assign y   = a | b;
  assign any = |y;

  // clr clears only the accumulated state; y_q, any_q and rise ignore it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q    <= '0;
      sticky <= '0;
      any_q  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      y_q   <= y;
      any_q <= any;
      rise  <= any & ~any_q;
      if (clr) sticky <= '0;
      else     sticky <= sticky | y;
    end
  end

`ifdef GOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                   act_cnt <= '0;
    else if (clr)                 act_cnt <= '0;
    else if (any && act_cnt != '1) act_cnt <= act_cnt + 1'b1;
  end
`else
  // Counter width is only meaningful with the statistics build.
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_gor.sv
// Self-checking bench for gor: vector table, directed reset/clr/saturation
// sequences and randomized traffic against a behavioural model.
module tb_gor;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] a, b;
  logic [3:0] y, y_q, sticky;
  logic       any, rise;
  logic       a1, b1;
  logic       y1, y1_q, sticky1, any1, rise1;
`ifdef GOR_STATS_EN
  logic [3:0] act_cnt, act_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural reference state
  logic [3:0] m_yq, m_sticky;
  logic       m_rise, m_prev_any;
  int         m_cnt;

  gor #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .y(y), .y_q(y_q), .sticky(sticky), .any(any), .rise(rise)
`ifdef GOR_STATS_EN
    , .act_cnt(act_cnt)
`endif
  );

  gor #(.WIDTH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr),
    .y(y1), .y_q(y1_q), .sticky(sticky1), .any(any1), .rise(rise1)
`ifdef GOR_STATS_EN
    , .act_cnt(act_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, check combinational outputs, clock once, check registered outputs.
  task automatic step(input logic [3:0] na, input logic [3:0] nb,
                      input logic nclr, input logic nrst);
    logic [3:0] ey;
    a = na; b = nb; clr = nclr; rst_n = nrst;
    ey = na | nb;
    #1;
    chk("y", 32'(y), 32'(ey));
    chk("any", 32'(any), 32'(ey != 4'd0));
    @(posedge clk);
    if (!nrst) begin
      m_yq = '0; m_sticky = '0; m_rise = 1'b0; m_prev_any = 1'b0; m_cnt = 0;
    end else begin
      m_rise     = (ey != 4'd0) && !m_prev_any;
      m_prev_any = (ey != 4'd0);
      m_yq       = ey;
      m_sticky   = nclr ? 4'd0 : (m_sticky | ey);
      if (nclr)              m_cnt = 0;
      else if (ey != 4'd0)   m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    end
    #1;
    chk("y_q", 32'(y_q), 32'(m_yq));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("rise", 32'(rise), 32'(m_rise));
`ifdef GOR_STATS_EN
    chk("act_cnt", 32'(act_cnt), 32'(m_cnt));
`endif
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       any;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } tt_t;

  vec_t tbl[6];
  tt_t  tt[4];

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b1};
    tt[2] = '{1'b1, 1'b0, 1'b1};
    tt[3] = '{1'b1, 1'b1, 1'b1};
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b0101, 4'b0011, 4'b0111, 1'b1};
    tbl[2] = '{4'b1000, 4'b0000, 4'b1000, 1'b1};
    tbl[3] = '{4'b1010, 4'b0101, 4'b1111, 1'b1};
    tbl[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b1};
    tbl[5] = '{4'b0000, 4'b0001, 4'b0001, 1'b1};

    a = '0; b = '0; a1 = 1'b0; b1 = 1'b0; clr = 1'b0; rst_n = 1'b0;
    m_yq = '0; m_sticky = '0; m_rise = 1'b0; m_prev_any = 1'b0; m_cnt = 0;

    // Single-bit truth table, combinational, checked within each step.
    for (int unsigned i = 0; i < 4; i++) begin
      a1 = tt[i].a; b1 = tt[i].b;
      #1;
      chk("tt_y1", 32'(y1), 32'(tt[i].y));
      chk("tt_any1", 32'(any1), 32'(tt[i].y));
      #9;
    end

    // Reset state, then combinational vectors held in reset.
    step(4'd0, 4'd0, 1'b0, 1'b0);
    step(4'd0, 4'd0, 1'b0, 1'b0);
    chk("rst_y_q", 32'(y_q), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_rise", 32'(rise), 32'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      a = tbl[i].a; b = tbl[i].b;
      #1;
      chk("vec_y", 32'(y), 32'(tbl[i].y));
      chk("vec_any", 32'(any), 32'(tbl[i].any));
    end

    // Release with a=1: y_q/sticky set, one-cycle rise.
    step(4'd1, 4'd0, 1'b0, 1'b1);
    chk("rel_y_q", 32'(y_q), 32'd1);
    chk("rel_rise", 32'(rise), 32'd1);
    chk("rel_sticky", 32'(sticky), 32'd1);
    step(4'd1, 4'd0, 1'b0, 1'b1);
    chk("rise_once", 32'(rise), 32'd0);
    for (int unsigned i = 0; i < 3; i++) step(4'd0, 4'd0, 1'b0, 1'b1);
    chk("idle_y_q", 32'(y_q), 32'd0);
    chk("idle_sticky", 32'(sticky), 32'd1);
    step(4'd0, 4'd0, 1'b1, 1'b1);
    chk("clr_sticky", 32'(sticky), 32'd0);
    // clr beats a simultaneous set; y_q unaffected by clr.
    step(4'd6, 4'd0, 1'b1, 1'b1);
    chk("clr_win_sticky", 32'(sticky), 32'd0);
    chk("clr_y_q", 32'(y_q), 32'd6);

    // Saturation of the activity counter.
    step(4'd0, 4'd0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 20; i++) step(4'd1, 4'd0, 1'b0, 1'b1);
`ifdef GOR_STATS_EN
    chk("sat_cnt", 32'(act_cnt), 32'd15);
    step(4'd1, 4'd0, 1'b1, 1'b1);
    chk("clr_cnt", 32'(act_cnt), 32'd0);
`endif

    // Mid-stream reset discards everything.
    step(4'b0101, 4'b0011, 1'b0, 1'b1);
    step(4'b0101, 4'b0011, 1'b0, 1'b1);
    step(4'b0101, 4'b0011, 1'b0, 1'b0);
    chk("mid_y_q", 32'(y_q), 32'd0);
    chk("mid_sticky", 32'(sticky), 32'd0);
    chk("mid_rise", 32'(rise), 32'd0);
    chk("mid_y", 32'(y), 32'b0111);

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 300; i++) begin
      logic [3:0] ra, rb;
      ra = (($urandom % 3) == 0) ? 4'd0 : 4'($urandom);
      rb = (($urandom % 3) == 0) ? 4'd0 : 4'($urandom);
      step(ra, rb, ($urandom % 10) == 0, ($urandom % 30) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
